// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
package riscv_mem_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int unsigned MEM_WORDS_DEF = 32'd1024;
  localparam int unsigned MEM_BYTES     = 32'd4 * MEM_WORDS_DEF;

  typedef struct packed {
    logic port;
    logic is_read;
    logic err;
  } rsp_tag_t;

  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return (lo_bits != 2'b00);
  endfunction

endpackage

// File: rtl/riscv_rr_arbiter2.sv
// Two-way round-robin grant; rr_last remembers the most recently granted port.
module riscv_rr_arbiter2
  import riscv_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_if,
  input  logic req_d,
  output logic gnt_if,
  output logic gnt_d
);

  logic rr_last_q;
  logic rr_last_d;

  // Grant selection; nothing is granted while reset is held low.
  always_comb begin
    gnt_if    = 1'b0;
    gnt_d     = 1'b0;
    rr_last_d = rr_last_q;
    if (!reset) begin
      gnt_if = 1'b0;
      gnt_d  = 1'b0;
    end else begin
      case ({req_if, req_d})
        2'b10:   gnt_if = 1'b1;
        2'b01:   gnt_d  = 1'b1;
        2'b11: begin
          if (rr_last_q == PORT_D) begin
            gnt_if = 1'b1;
          end else begin
            gnt_d = 1'b1;
          end
        end
        default: begin
          gnt_if = 1'b0;
          gnt_d  = 1'b0;
        end
      endcase
    end
    // Every grant is an acceptance, since the SRAM never stalls.
    if (gnt_if) begin
      rr_last_d = PORT_IF;
    end else if (gnt_d) begin
      rr_last_d = PORT_D;
    end else begin
      rr_last_d = rr_last_q;
    end
  end

  // Last-granted register; the data port counts as last so fetch wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q <= PORT_D;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port word SRAM between fetch and data ports, with address
// decode, error responses and a saturating contention counter.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned MA        = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rsp_rdata,
  output logic                  if_rsp_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [31:0]           d_req_wdata,
  input  logic [3:0]            d_req_wstrb,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rsp_rdata,
  output logic                  d_rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MA-1:0]         mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  output logic [CNT_WIDTH-1:0]  contention_cnt
);

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(64'(MEM_WORDS) * 64'd4);

  logic                  gnt_if_s;
  logic                  gnt_d_s;
  logic                  granted_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  err_s;

  rsp_tag_t              tag_q;
  rsp_tag_t              tag_d;
  logic                  rsp_valid_q;
  logic                  rsp_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;

  riscv_rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_if (if_req_valid),
    .req_d  (d_req_valid),
    .gnt_if (gnt_if_s),
    .gnt_d  (gnt_d_s)
  );

  assign if_req_ready = gnt_if_s;
  assign d_req_ready  = gnt_d_s;

  // Decode the granted request and drive the SRAM; errored requests never reach it.
  always_comb begin
    granted_s = gnt_if_s | gnt_d_s;
    addr_s    = gnt_d_s ? d_req_addr : if_req_addr;
    err_s     = granted_s &&
                (is_misaligned(addr_s[1:0]) || ({1'b0, addr_s} >= MEM_LIMIT));
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0000_0000;
    mem_wstrb = 4'b0000;
    if (granted_s && !err_s) begin
      mem_en    = 1'b1;
      mem_we    = gnt_d_s & d_req_we;
      mem_addr  = addr_s[2 +: MA];
      mem_wdata = gnt_d_s ? d_req_wdata : 32'h0000_0000;
      mem_wstrb = gnt_d_s ? d_req_wstrb : 4'b0000;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Next-state for the response tag and contention counter.
  always_comb begin
    rsp_valid_d   = granted_s;
    tag_d.port    = gnt_d_s ? PORT_D : PORT_IF;
    tag_d.is_read = !(gnt_d_s && d_req_we);
    tag_d.err     = err_s;
    if (if_req_valid && d_req_valid && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Response pipeline stage and counter; reset drops any response in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      tag_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
    end
  end

  // Route the one-cycle-late response to its owner; read data only for legal reads.
  always_comb begin
    if_rsp_valid = rsp_valid_q && (tag_q.port == PORT_IF);
    d_rsp_valid  = rsp_valid_q && (tag_q.port == PORT_D);
    if_rsp_err   = if_rsp_valid && tag_q.err;
    d_rsp_err    = d_rsp_valid && tag_q.err;
    if (if_rsp_valid && tag_q.is_read && !tag_q.err) begin
      if_rsp_rdata = mem_rdata;
    end else begin
      if_rsp_rdata = 32'h0000_0000;
    end
    if (d_rsp_valid && tag_q.is_read && !tag_q.err) begin
      d_rsp_rdata = mem_rdata;
    end else begin
      d_rsp_rdata = 32'h0000_0000;
    end
  end

  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized and directed bench for riscv_mem_arbiter against a transaction-level model.
module tb_riscv_mem_arbiter;

  localparam int AW = 32;
  localparam int MW = 1024;
  localparam int CW = 16;
  localparam int MA = $clog2(MW);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req_valid = 1'b0;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_rsp_valid;
  logic [31:0]   if_rsp_rdata;
  logic          if_rsp_err;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic          d_req_we = 1'b0;
  logic [AW-1:0] d_req_addr = '0;
  logic [31:0]   d_req_wdata = '0;
  logic [3:0]    d_req_wstrb = '0;
  logic          d_rsp_valid;
  logic [31:0]   d_rsp_rdata;
  logic          d_rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [MA-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] contention_cnt;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_WIDTH(AW), .MEM_WORDS(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .contention_cnt(contention_cnt)
  );

  // SRAM macro behaviour: byte-strobed write, registered read.
  logic [31:0] sram [MW];
  logic [31:0] sram_rdata = '0;
  assign mem_rdata = sram_rdata;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram[mem_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected memory image, last winner, one pending response, count.
  logic [31:0] ref_mem [MW];
  int          last_win;
  bit          pv;
  int          pport;
  bit          perr;
  logic [31:0] pdata;
  longint      mcnt;
  int          last_g = -1;

  task automatic step();
    int g;
    longint unsigned a;
    bit e;
    #1;
    if (!reset) begin
      check_eq("rst_if_ready", if_req_ready, 0);
      check_eq("rst_d_ready", d_req_ready, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_if_rsp", if_rsp_valid, 0);
      check_eq("rst_d_rsp", d_rsp_valid, 0);
      check_eq("rst_cnt", contention_cnt, 0);
      pv = 0; last_win = 1; mcnt = 0; last_g = -1;
    end else begin
      check_eq("if_rsp_valid", if_rsp_valid, (pv && pport == 0));
      check_eq("d_rsp_valid", d_rsp_valid, (pv && pport == 1));
      if (pv && pport == 0) begin
        check_eq("if_rsp_err", if_rsp_err, perr);
        check_eq("if_rsp_rdata", if_rsp_rdata, pdata);
      end else if (pv) begin
        check_eq("d_rsp_err", d_rsp_err, perr);
        check_eq("d_rsp_rdata", d_rsp_rdata, pdata);
      end
      check_eq("cnt", contention_cnt, mcnt);
      g = -1;
      if (if_req_valid && d_req_valid) g = (last_win == 1) ? 0 : 1;
      else if (if_req_valid) g = 0;
      else if (d_req_valid) g = 1;
      check_eq("if_ready", if_req_ready, (g == 0));
      check_eq("d_ready", d_req_ready, (g == 1));
      if (g < 0) begin
        check_eq("idle_mem_en", mem_en, 0);
        check_eq("idle_mem_we", mem_we, 0);
        check_eq("idle_mem_addr", mem_addr, 0);
        check_eq("idle_mem_wdata", mem_wdata, 0);
        check_eq("idle_mem_wstrb", mem_wstrb, 0);
        pv = 0;
      end else begin
        a = (g == 1) ? d_req_addr : if_req_addr;
        e = (a % 4 != 0) || (a >= 4 * MW);
        check_eq("mem_en", mem_en, !e);
        if (!e) begin
          check_eq("mem_we", mem_we, (g == 1 && d_req_we));
          check_eq("mem_addr", mem_addr, a / 4);
          check_eq("mem_wdata", mem_wdata, (g == 1) ? d_req_wdata : 0);
          check_eq("mem_wstrb", mem_wstrb, (g == 1) ? d_req_wstrb : 0);
        end
        pv = 1; pport = g; perr = e;
        pdata = (!e && (g == 0 || !d_req_we)) ? ref_mem[a / 4] : 32'h0;
        if (!e && g == 1 && d_req_we)
          for (int b = 0; b < 4; b++)
            if (d_req_wstrb[b]) ref_mem[a / 4][8*b +: 8] = d_req_wdata[8*b +: 8];
        last_win = g;
      end
      last_g = g;
      if (if_req_valid && d_req_valid && mcnt < 65535) mcnt++;
    end
  endtask

  task automatic drive(input bit iv, input logic [31:0] ia, input bit dv, input bit dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dws);
    if_req_valid = iv; if_req_addr = ia;
    d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd; d_req_wstrb = dws;
  endtask

  task automatic cyc(input bit iv, input logic [31:0] ia, input bit dv, input bit dwe,
                     input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dws);
    @(negedge clk);
    drive(iv, ia, dv, dwe, da, dwd, dws);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 1) return 32'(4 * MW) + (32'($urandom_range(0, 15)) << 2);
    else if (r == 2) return 32'hFFFF_FFFC;
    else return 32'($urandom_range(0, 31)) << 2;
  endfunction

  initial begin
    for (int i = 0; i < MW; i++) begin
      sram[i]    = 32'(i) * 32'h9E37_79B1;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    end
    sram[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    last_win = 1; pv = 0; mcnt = 0;

    // Fetch-only read of word 4 straight after reset.
    do_reset();
    cyc(1, 32'h10, 0, 0, 0, 0, 0);
    check_eq("t1_mem_addr", mem_addr, 4);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_eq("t1_rdata", if_rsp_rdata, 32'hDEAD_BEEF);

    // Sustained contention: F, D, F, D.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h0, 1, 0, 32'h8, 0, 0);
      check_eq("t2_grant_if", if_req_ready, (i % 2 == 0));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_eq("t2_cnt", contention_cnt, 4);

    // Partial write then readback.
    cyc(0, 0, 1, 1, 32'h20, 32'h1122_3344, 4'b0011);
    cyc(0, 0, 1, 0, 32'h20, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_eq("t3_rdata", d_rsp_rdata, {ref_mem[8][31:16], 16'h3344});

    // Zero-strobe write is a legal access.
    cyc(0, 0, 1, 1, 32'h24, 32'hFFFF_FFFF, 4'b0000);
    check_eq("t3_zero_strb_en", mem_en, 1);

    // Out-of-range data read, misaligned fetch.
    cyc(0, 0, 1, 0, 32'(4 * MW), 0, 0);
    cyc(1, 32'h6, 0, 0, 0, 0, 0);
    check_eq("t4_oor_err", d_rsp_err, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_eq("t4_mis_err", if_rsp_err, 1);

    // Reset right after a fetch acceptance drops its response.
    cyc(0, 0, 1, 0, 32'h8, 0, 0);
    cyc(1, 32'h10, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    drive(1, 32'h10, 1, 0, 32'h8, 0, 0);
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
    check_eq("t5_tie_fetch", if_req_ready, 1);

    // Random traffic with held requests.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (if_req_valid && last_g != 0 && $urandom_range(0, 15) != 0) begin
        if_req_valid = 1'b1;
      end else begin
        if_req_valid = ($urandom_range(0, 9) < 6);
        if_req_addr  = rand_addr();
      end
      if (d_req_valid && last_g != 1 && $urandom_range(0, 15) != 0) begin
        d_req_valid = 1'b1;
      end else begin
        d_req_valid = ($urandom_range(0, 9) < 6);
        d_req_we    = $urandom_range(0, 1);
        d_req_addr  = rand_addr();
        d_req_wdata = $urandom;
        d_req_wstrb = 4'($urandom_range(0, 15));
      end
      step();
    end

    // Counter saturation.
    do_reset();
    @(negedge clk);
    drive(1, 32'h0, 1, 0, 32'h8, 0, 0);
    repeat (65534) @(negedge clk);
    #1 check_eq("sat_fffe", contention_cnt, 16'hFFFE);
    @(negedge clk);
    #1 check_eq("sat_ffff", contention_cnt, 16'hFFFF);
    repeat (6) @(negedge clk);
    #1 check_eq("sat_hold", contention_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
